// File: rtl/cpu_run_controller_if.sv
// Host-side streaming interface of the run controller: a load stream into
// the controller and a dump stream back out to the host.
interface cpu_run_controller_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;

   // Host side drives load words and accepts dump words
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Controller side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/cpu_run_controller.sv
// Host-side sequencer for the pipelined RISC-V core: loads instruction and
// data memory from the host stream, runs the core for a fixed number of
// cycles, then streams data memory back to the host.
module cpu_run_controller #(
   parameter int IMEM_DEPTH = 512,
   parameter int DMEM_DEPTH = 1024,
   parameter int CYC_W      = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [9:0]       imem_len,
   input  logic [10:0]      dmem_len,
   input  logic [CYC_W-1:0] run_cycles,
   cpu_run_controller_if.slave host,
   output logic             busy,
   output logic             done,
   output logic [CYC_W-1:0] cycle_count,
   output logic             cpu_enable,
   output logic [63:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   output logic [63:0]      addr_ext_2,
   output logic             wen_ext_2,
   output logic             ren_ext_2,
   output logic [63:0]      wdata_ext_2,
   input  logic [63:0]      rdata_ext_2
);

   typedef enum logic [3:0] {
      IDLE,
      LOAD_I,
      LOAD_D,
      SETTLE,
      RUN,
      DUMP_RD,
      DUMP_WT,
      DUMP_OUT,
      DONE
   } state_t;

   localparam logic [10:0]      IMEM_MAX = 11'(IMEM_DEPTH);
   localparam logic [10:0]      DMEM_MAX = 11'(DMEM_DEPTH);
   localparam logic [10:0]      IDX_ONE  = 11'd1;
   localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

   state_t           state;
   logic [10:0]      imem_cnt;
   logic [10:0]      dmem_cnt;
   logic [CYC_W-1:0] run_len;
   logic [10:0]      idx;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [63:0]      out_data_r;

   logic [10:0]      imem_sat;
   logic [10:0]      dmem_sat;
   logic [10:0]      idx_next;
   logic             in_hs;
   logic             run_last;

   assign host.in_ready  = in_ready_r;
   assign host.out_valid = out_valid_r;
   assign host.out_data  = out_data_r;

   // The instruction memory is never read from this side
   assign ren_ext = 1'b0;

   // Requested lengths clipped to the memory depths, plus shared helpers
   always_comb begin
      imem_sat = ({1'b0, imem_len} > IMEM_MAX) ? IMEM_MAX : {1'b0, imem_len};
      dmem_sat = (dmem_len > DMEM_MAX) ? DMEM_MAX : dmem_len;
      idx_next = idx + IDX_ONE;
      in_hs    = host.in_valid & in_ready_r;
      run_last = ((cycle_count + CYC_ONE) == run_len);
   end

   // Sequencer: every output is a register; memory-port outputs fall back to
   // zero each cycle unless a state actively drives them
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= IDLE;
         imem_cnt    <= '0;
         dmem_cnt    <= '0;
         run_len     <= '0;
         idx         <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cycle_count <= '0;
         cpu_enable  <= 1'b0;
         addr_ext    <= '0;
         wen_ext     <= 1'b0;
         wdata_ext   <= '0;
         addr_ext_2  <= '0;
         wen_ext_2   <= 1'b0;
         ren_ext_2   <= 1'b0;
         wdata_ext_2 <= '0;
      end else begin
         wen_ext     <= 1'b0;
         addr_ext    <= '0;
         wdata_ext   <= '0;
         wen_ext_2   <= 1'b0;
         ren_ext_2   <= 1'b0;
         addr_ext_2  <= '0;
         wdata_ext_2 <= '0;
         cpu_enable  <= 1'b0;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  imem_cnt    <= imem_sat;
                  dmem_cnt    <= dmem_sat;
                  run_len     <= run_cycles;
                  idx         <= '0;
                  cycle_count <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  in_ready_r  <= (imem_sat != 11'd0);
                  state       <= LOAD_I;
               end
            end

            LOAD_I: begin
               if (!in_ready_r) begin
                  in_ready_r <= (dmem_cnt != 11'd0);
                  state      <= LOAD_D;
               end else if (in_hs) begin
                  wen_ext   <= 1'b1;
                  addr_ext  <= {51'd0, idx, 2'b00};
                  wdata_ext <= host.in_data[31:0];
                  if (idx_next == imem_cnt) begin
                     idx        <= '0;
                     in_ready_r <= (dmem_cnt != 11'd0);
                     state      <= LOAD_D;
                  end else begin
                     idx <= idx_next;
                  end
               end
            end

            LOAD_D: begin
               if (!in_ready_r) begin
                  state <= SETTLE;
               end else if (in_hs) begin
                  wen_ext_2   <= 1'b1;
                  addr_ext_2  <= {50'd0, idx, 3'b000};
                  wdata_ext_2 <= host.in_data;
                  if (idx_next == dmem_cnt) begin
                     idx        <= '0;
                     in_ready_r <= 1'b0;
                     state      <= SETTLE;
                  end else begin
                     idx <= idx_next;
                  end
               end
            end

            SETTLE: begin
               if (run_len != '0) begin
                  cpu_enable <= 1'b1;
                  state      <= RUN;
               end else if (dmem_cnt != 11'd0) begin
                  ren_ext_2  <= 1'b1;
                  addr_ext_2 <= '0;
                  state      <= DUMP_RD;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end

            RUN: begin
               cycle_count <= cycle_count + CYC_ONE;
               if (!run_last) begin
                  cpu_enable <= 1'b1;
               end else if (dmem_cnt != 11'd0) begin
                  ren_ext_2  <= 1'b1;
                  addr_ext_2 <= '0;
                  state      <= DUMP_RD;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end

            DUMP_RD: begin
               state <= DUMP_WT;
            end

            DUMP_WT: begin
               out_data_r  <= rdata_ext_2;
               out_valid_r <= 1'b1;
               state       <= DUMP_OUT;
            end

            DUMP_OUT: begin
               if (host.out_ready) begin
                  out_valid_r <= 1'b0;
                  if (idx_next < dmem_cnt) begin
                     idx        <= idx_next;
                     ren_ext_2  <= 1'b1;
                     addr_ext_2 <= {50'd0, idx_next, 3'b000};
                     state      <= DUMP_RD;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: stimulus pushes expected memory
// writes, reads and dump words into queues; a negedge monitor pops and
// compares whenever the controller presents one of them.
module tb_cpu_run_controller;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        start;
   logic [9:0]  imem_len;
   logic [10:0] dmem_len;
   logic [31:0] run_cycles;
   logic        busy;
   logic        done;
   logic [31:0] cycle_count;
   logic        cpu_enable;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic [63:0] rdata_ext_2 = '0;

   cpu_run_controller_if bus ();

   cpu_run_controller dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .imem_len    (imem_len),
      .dmem_len    (dmem_len),
      .run_cycles  (run_cycles),
      .host        (bus),
      .busy        (busy),
      .done        (done),
      .cycle_count (cycle_count),
      .cpu_enable  (cpu_enable),
      .addr_ext    (addr_ext),
      .wen_ext     (wen_ext),
      .ren_ext     (ren_ext),
      .wdata_ext   (wdata_ext),
      .addr_ext_2  (addr_ext_2),
      .wen_ext_2   (wen_ext_2),
      .ren_ext_2   (ren_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .rdata_ext_2 (rdata_ext_2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_iaddr[$];
   logic [63:0] exp_idata[$];
   logic [63:0] exp_daddr[$];
   logic [63:0] exp_ddata[$];
   logic [63:0] exp_raddr[$];
   logic [63:0] exp_out[$];
   logic [63:0] load_words[$];

   logic [63:0] dmem_model [0:1023];

   int          en_total    = 0;
   int          ov_total    = 0;
   int          streak      = 0;
   int          last_streak = 0;
   logic        prev_stall  = 1'b0;
   logic [63:0] prev_data   = '0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic flag_unexpected(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got an event, expected none", name);
   endtask

   // Behavioural data memory: write on wen, read data one cycle after ren
   always @(posedge clk) begin
      if (wen_ext_2) dmem_model[addr_ext_2[12:3]] <= wdata_ext_2;
      rdata_ext_2 <= ren_ext_2 ? dmem_model[addr_ext_2[12:3]] : 64'd0;
   end

   // Monitor: compares every presented write, read and dump word against the scoreboard
   always @(negedge clk) begin
      if (wen_ext) begin
         if (exp_iaddr.size() == 0) flag_unexpected("imem_write");
         else begin
            check_output("imem_addr", addr_ext, exp_iaddr.pop_front());
            check_output("imem_data", {32'd0, wdata_ext}, exp_idata.pop_front());
         end
      end
      if (wen_ext_2) begin
         if (exp_daddr.size() == 0) flag_unexpected("dmem_write");
         else begin
            check_output("dmem_addr", addr_ext_2, exp_daddr.pop_front());
            check_output("dmem_data", wdata_ext_2, exp_ddata.pop_front());
         end
      end
      if (ren_ext_2) begin
         if (exp_raddr.size() == 0) flag_unexpected("dmem_read");
         else check_output("dmem_read_addr", addr_ext_2, exp_raddr.pop_front());
      end
      if (prev_stall) begin
         check_output("stall_valid", {63'd0, bus.out_valid}, 64'd1);
         check_output("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid) ov_total++;
      if (bus.out_valid && bus.out_ready) begin
         if (exp_out.size() == 0) flag_unexpected("dump_word");
         else check_output("dump_word", bus.out_data, exp_out.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (cpu_enable) begin
         en_total++;
         streak++;
      end else if (streak > 0) begin
         last_streak = streak;
         streak      = 0;
      end
   end

   task automatic clear_scoreboard();
      exp_iaddr.delete();
      exp_idata.delete();
      exp_daddr.delete();
      exp_ddata.delete();
      exp_raddr.delete();
      exp_out.delete();
      load_words.delete();
   endtask

   // One full sequence: vmode 0=valid held,1=toggle,2=random; rmode 0=ready held,
   // 1=four stall cycles on dump word 1, 2=random; reset_at>=0 aborts at that cycle_count
   task automatic apply_stimulus(input int l, input int d, input int r, input int vmode,
                                 input int rmode, input bit mid_start, input int reset_at);
      int ni, nd, cyc, popped, out_word, stall_left, en0, ov0;
      bit tog, hs, ohs, seen, mid_done;
      logic [63:0] w;
      ni = (l > 512) ? 512 : l;
      nd = (d > 1024) ? 1024 : d;
      clear_scoreboard();
      for (int i = 0; i < ni; i++) begin
         w = {$urandom, $urandom};
         load_words.push_back(w);
         exp_iaddr.push_back(64'(i * 4));
         exp_idata.push_back({32'd0, w[31:0]});
      end
      for (int j = 0; j < nd; j++) begin
         w = {$urandom, $urandom};
         load_words.push_back(w);
         exp_daddr.push_back(64'(j * 8));
         exp_ddata.push_back(w);
         exp_raddr.push_back(64'(j * 8));
         exp_out.push_back(w);
      end
      en0 = en_total;
      ov0 = ov_total;
      @(posedge clk); #1;
      start      = 1'b1;
      imem_len   = 10'(l);
      dmem_len   = 11'(d);
      run_cycles = 32'(r);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; popped = 0; out_word = 0; stall_left = 4;
      tog = 1'b1; seen = 1'b0; mid_done = 1'b0;
      while (!seen && cyc < 6000) begin
         cyc++;
         if (load_words.size() > 0) begin
            case (vmode)
               0:       bus.in_valid = 1'b1;
               1:       bus.in_valid = tog;
               default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            bus.in_data = load_words[0];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
         end
         tog = ~tog;
         case (rmode)
            0: bus.out_ready = 1'b1;
            1: begin
               if (bus.out_valid && out_word == 1 && stall_left > 0) begin
                  bus.out_ready = 1'b0;
                  stall_left--;
               end else bus.out_ready = 1'b1;
            end
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         if (mid_start && !mid_done && popped == ni + 1) begin
            start    = 1'b1;
            imem_len = 10'd7;
            dmem_len = 11'd1;
            mid_done = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         hs   = bus.in_valid && bus.in_ready;
         ohs  = bus.out_valid && bus.out_ready;
         seen = done;
         if (reset_at >= 0 && cycle_count == 32'(reset_at)) begin
            #2 arst_n = 1'b0;
            #1;
            check_output("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
            check_output("rst_wen_ext", {63'd0, wen_ext}, 64'd0);
            check_output("rst_wen_ext_2", {63'd0, wen_ext_2}, 64'd0);
            check_output("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
            check_output("rst_busy", {63'd0, busy}, 64'd0);
            check_output("rst_cycle_count", {32'd0, cycle_count}, 64'd0);
            check_output("rst_loads_done", 64'(exp_iaddr.size() + exp_daddr.size()), 64'd0);
            clear_scoreboard();
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            arst_n = 1'b1;
            return;
         end
         @(posedge clk); #1;
         if (hs) begin
            void'(load_words.pop_front());
            popped++;
         end
         if (ohs) out_word++;
      end
      bus.in_valid = 1'b0;
      start        = 1'b0;
      if (!seen) flag_unexpected("timeout_waiting_done");
      check_output("imem_writes_left", 64'(exp_iaddr.size()), 64'd0);
      check_output("dmem_writes_left", 64'(exp_daddr.size()), 64'd0);
      check_output("dmem_reads_left", 64'(exp_raddr.size()), 64'd0);
      check_output("dump_words_left", 64'(exp_out.size()), 64'd0);
      check_output("enabled_cycles", 64'(en_total - en0), 64'(r));
      check_output("cycle_count", {32'd0, cycle_count}, 64'(r));
      check_output("done_flag", {63'd0, done}, 64'd1);
      check_output("busy_at_done", {63'd0, busy}, 64'd0);
      if (r > 0) check_output("enable_contiguous", 64'(last_streak), 64'(r));
      if (l == 0 && d == 0 && r == 0) begin
         check_output("zero_len_latency_ok", {63'd0, (cyc <= 4)}, 64'd1);
         check_output("zero_len_out_valid", 64'(ov_total - ov0), 64'd0);
      end
      clear_scoreboard();
   endtask

   initial begin
      arst_n        = 1'b1;
      start         = 1'b0;
      imem_len      = '0;
      dmem_len      = '0;
      run_cycles    = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #2 arst_n = 1'b0;
      #2;
      check_output("reset_busy", {63'd0, busy}, 64'd0);
      check_output("reset_done", {63'd0, done}, 64'd0);
      check_output("reset_cycle_count", {32'd0, cycle_count}, 64'd0);
      check_output("reset_cpu_enable", {63'd0, cpu_enable}, 64'd0);
      check_output("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check_output("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check_output("reset_ren_ext", {63'd0, ren_ext}, 64'd0);
      @(negedge clk);
      arst_n = 1'b1;

      $display("[TB] basic sequence");
      apply_stimulus(3, 2, 5, 0, 0, 1'b0, -1);
      $display("[TB] reset during run");
      apply_stimulus(2, 2, 100, 0, 0, 1'b0, 7);
      apply_stimulus(4, 3, 6, 0, 0, 1'b0, -1);
      $display("[TB] load gaps");
      apply_stimulus(5, 4, 3, 1, 0, 1'b0, -1);
      $display("[TB] dump backpressure");
      apply_stimulus(2, 4, 2, 0, 1, 1'b0, -1);
      $display("[TB] zero lengths");
      apply_stimulus(0, 0, 0, 0, 0, 1'b0, -1);
      apply_stimulus(0, 3, 0, 2, 2, 1'b0, -1);
      $display("[TB] saturation and ignored start");
      apply_stimulus(600, 4, 3, 0, 0, 1'b1, -1);
      $display("[TB] random runs");
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(int'($urandom_range(0, 20)), int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 30)), 2, 2, 1'b0, -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Host-side sequencer for the pipelined RISC-V core. It owns the core's external instruction-memory and data-memory ports and its `enable` input. On `start` it does four things in order:
- streams a program into instruction memory;
- streams an initial image into data memory;
- runs the core for a programmed number of cycles;
- streams the data-memory contents back out.

It sits between the test host and the cpu top level.

Parameters:
- IMEM_DEPTH, 512, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 1024, data memory depth in 64-bit words.
- CYC_W, 32, width of the run-cycle count and cycle counter.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- imem_len  in  10  instruction words to load (0..512)
- dmem_len  in  11  data words to load and dump (0..1024)
- run_cycles  in  CYC_W  cycles with enable high
- in_valid  in  1  host load word valid
- in_ready  out  1  controller accepts load word
- in_data  in  64  load word; bits [31:0] used for imem
- out_valid  out  1  dump word valid
- out_ready  in  1  host accepts dump word
- out_data  out  64  dumped data-memory word
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high in DONE
- cycle_count  out  CYC_W  enabled cycles elapsed in the current run
- cpu_enable  out  1  drives cpu enable
- addr_ext  out  64  imem external byte address
- wen_ext  out  1  imem external write enable
- ren_ext  out  1  tied 0
- wdata_ext  out  32  imem external write data
- addr_ext_2  out  64  dmem external byte address
- wen_ext_2  out  1  dmem external write enable
- ren_ext_2  out  1  dmem external read enable
- wdata_ext_2  out  64  dmem external write data
- rdata_ext_2  in  64  dmem external read data; valid the cycle after ren_ext_2

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including cycle_count, counters and registered write port.
- On accepted start:
  - latch imem_len and dmem_len, each saturated to its DEPTH; latch run_cycles;
  - clear the word index and cycle_count;
  - go to LOAD_I.
- start outside IDLE/DONE is ignored.
- States: IDLE, LOAD_I, LOAD_D, SETTLE, RUN, DUMP_RD, DUMP_WT, DUMP_OUT, DONE.
- LOAD_I:
  - in_ready=1.
  - Each handshake (in_valid&in_ready) registers one imem write. Next cycle: wen_ext=1, addr_ext=idx*4, wdata_ext=in_data[31:0].
  - idx increments per handshake. Back-to-back handshakes give one write per cycle.
  - After handshake number imem_len, go to LOAD_D with idx=0.
  - imem_len=0: LOAD_I lasts one cycle with in_ready=0.
- LOAD_D: same rules as LOAD_I, with wen_ext_2, addr_ext_2=idx*8, wdata_ext_2=in_data. Exits to SETTLE.
- SETTLE: exactly one cycle. The registered final write completes here; in_ready=0.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles; cycle_count increments each of them.
  - run_cycles=0: zero enabled cycles, skip straight to dump.
  - cpu_enable is 0 in every other state.
- Dump loop, per k in 0..dmem_len-1:
  - DUMP_RD: ren_ext_2=1, addr_ext_2=k*8, one cycle.
  - DUMP_WT: capture rdata_ext_2 into out_data, one cycle.
  - DUMP_OUT: out_valid=1 holding out_data until out_ready. On handshake: if k<dmem_len-1 go to DUMP_RD with k+1, else go to DONE.
  - dmem_len=0: skip the dump, go to DONE.
- Backpressure: out_data and out_valid are stable while out_valid=1 and out_ready=0.
- DONE: done=1; cycle_count holds. A start here re-runs the full sequence.
- Ext-port outputs are 0 whenever not actively driven. Addresses are zero-extended to 64 bits.
- Reset mid-operation aborts immediately; no partial write completes after arst_n falls.

Test Plan:
- Reset during RUN (cycle_count=7) -> cpu_enable, wen_ext*, out_valid, busy and cycle_count all 0 within the reset; state IDLE; next start runs normally.
- Basic sequence: imem_len=3, dmem_len=2, run_cycles=5, in_valid held high.
  - wen_ext writes at addresses 0,4,8, then wen_ext_2 writes at 0,8.
  - one SETTLE cycle, then cpu_enable high exactly 5 cycles; cycle_count=5.
  - reads at 0,8; two out words equal to the memory model contents; done=1.
- Load gaps: in_valid toggled 1,0,1,0 -> exactly one write per handshake; addresses strictly sequential; no write in gap cycles.
- Dump backpressure: out_ready low 4 cycles on word 1 -> out_valid and out_data stable for those cycles; no extra ren_ext_2 issued; word 2 follows after the handshake.
- Zero lengths: imem_len=0, dmem_len=0, run_cycles=0 -> no writes, no cpu_enable, no out_valid; done within 4 cycles of start.
- Saturation and ignored start: imem_len=600 -> exactly 512 imem writes, last at 0x7FC. start pulsed during LOAD_D -> ignored, sequence unaffected.
